// File: rtl/rnn_pkg.sv
// Shared types and helpers for the Elman RNN cell engine.
//   act_mode_e  : activation selection (hard-tanh / saturating ReLU)
//   rnn_state_e : engine sequencing states
//   wx_addr / b_addr / wh_addr : config address map helpers
//   acc_width   : minimum accumulator width for a given data width and H
package rnn_pkg;

  typedef enum logic {
    ACT_TANH = 1'b0,
    ACT_RELU = 1'b1
  } act_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_ACT  = 2'd2,
    ST_OUT  = 2'd3
  } rnn_state_e;

  function automatic int wx_addr(input int i);
    return i;
  endfunction

  function automatic int b_addr(input int h, input int i);
    return h + i;
  endfunction

  // wh_addr(h, h, 0) is one past the last valid address.
  function automatic int wh_addr(input int h, input int i, input int j);
    return 2 * h + i * h + j;
  endfunction

  function automatic int acc_width(input int dw, input int h);
    return 2 * dw + $clog2(h + 2);
  endfunction

endpackage

// File: rtl/rnn_cell_engine_if.sv
// Bus bundle for rnn_cell_engine: config write port, scalar input stream
// (valid/ready with first/last), per-neuron output stream and busy flag.
//   master : the side that feeds samples/weights and consumes outputs
//   slave  : the engine
interface rnn_cell_engine_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int HIDDEN_SIZE = 8,
  parameter int ADDR_W      = $clog2(2*HIDDEN_SIZE + HIDDEN_SIZE*HIDDEN_SIZE)
);
  localparam int IDX_W = $clog2(HIDDEN_SIZE);

  logic                         cfg_we;
  logic [ADDR_W-1:0]            cfg_addr;
  logic signed [DATA_WIDTH-1:0] cfg_wdata;
  logic                         cfg_err;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_first;
  logic                         in_last;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]             out_idx;
  logic                         out_last;
  logic                         busy;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, in_valid, in_data, in_first, in_last, out_ready,
    input  cfg_err, in_ready, out_valid, out_data, out_idx, out_last, busy
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_data, in_first, in_last, out_ready,
    output cfg_err, in_ready, out_valid, out_data, out_idx, out_last, busy
  );
endinterface

// File: rtl/rnn_act_sat.sv
// Combinational activation stage: drops FRAC_BITS from the accumulator
// (arithmetic shift, floor) then applies hard-tanh clipping to +/-1.0 or
// saturating ReLU.
//   acc  : signed accumulator, ACC_WIDTH bits, Q(2*FRAC_BITS)
//   mode : ACT_TANH / ACT_RELU
//   y    : activated value, DATA_WIDTH bits, Q(FRAC_BITS)
module rnn_act_sat
  import rnn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 40
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  input  act_mode_e                    mode,
  output logic signed [DATA_WIDTH-1:0] y
);
  localparam logic signed [ACC_WIDTH-1:0] ONE =
    {{(ACC_WIDTH-FRAC_BITS-1){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] NEG_ONE = -ONE;
  localparam logic signed [ACC_WIDTH-1:0] MAX_POS =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};

  function automatic logic signed [DATA_WIDTH-1:0] sat_tanh(input logic signed [ACC_WIDTH-1:0] v);
    if (v > ONE)          return ONE[DATA_WIDTH-1:0];
    else if (v < NEG_ONE) return NEG_ONE[DATA_WIDTH-1:0];
    else                  return v[DATA_WIDTH-1:0];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat_relu(input logic signed [ACC_WIDTH-1:0] v);
    if (v[ACC_WIDTH-1])   return '0;
    else if (v > MAX_POS) return MAX_POS[DATA_WIDTH-1:0];
    else                  return v[DATA_WIDTH-1:0];
  endfunction

  logic signed [ACC_WIDTH-1:0] v;

  assign v = acc >>> FRAC_BITS;
  assign y = (mode == ACT_RELU) ? sat_relu(v) : sat_tanh(v);
endmodule

// File: rtl/rnn_cell_engine.sv
// Streaming Elman RNN cell: h_t = act(Wx*x_t + Wh*h_{t-1} + b), one
// time-multiplexed MAC. Each accepted sample produces H neuron outputs.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rnn_cell_engine_if.slave (config port, input stream,
//              output stream, busy)
module rnn_cell_engine
  import rnn_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int HIDDEN_SIZE = 8,
  parameter int ACC_WIDTH   = 40,
  parameter int ACT_MODE    = 0,
  parameter int ADDR_W      = $clog2(2*HIDDEN_SIZE + HIDDEN_SIZE*HIDDEN_SIZE)
) (
  input logic              clk,
  input logic              rst,
  rnn_cell_engine_if.slave bus
);
  localparam int H     = HIDDEN_SIZE;
  localparam int IDX_W = $clog2(H);
  localparam int CNT_W = $clog2(H + 1);
  localparam int WORDS = wh_addr(H, H, 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(H);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(H - 1);
  localparam act_mode_e MODE = (ACT_MODE == 1) ? ACT_RELU : ACT_TANH;

  typedef logic signed [DATA_WIDTH-1:0]   word_t;
  typedef logic signed [2*DATA_WIDTH-1:0] prod_t;
  typedef logic signed [ACC_WIDTH-1:0]    acc_t;

  rnn_state_e       state_q, state_d;
  word_t            wx_q[H], wx_d[H], b_q[H], b_d[H], wh_q[H*H], wh_d[H*H];
  word_t            h_prev_q[H], h_prev_d[H], h_next_q[H], h_next_d[H];
  word_t            x_q, x_d, out_data_q, out_data_d;
  acc_t             acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d, out_idx_q, out_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seq_last_q, seq_last_d, out_last_q, out_last_d;
  logic             cfg_err_q, cfg_err_d;

  logic [ADDR_W-1:0] cfg_addr;
  int                cfg_a;
  logic              cfg_ok, in_fire, out_fire;
  word_t             wx_sel, b_sel, wh_sel, hp_sel, mul_a, mul_b, act_y;
  prod_t             prod;
  acc_t              bias_ext, prod_ext;

  assign cfg_addr = bus.cfg_addr;
  assign cfg_a    = int'(cfg_addr);
  // Writes are only accepted while idle so a step never sees a weight change mid-flight.
  assign cfg_ok   = bus.cfg_we && (state_q == ST_IDLE) && (cfg_a < WORDS);
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_fire) state_d = ST_MAC;
      ST_MAC:  if (cnt_q == CNT_LAST) state_d = ST_ACT;
      ST_ACT:  state_d = ST_OUT;
      ST_OUT:  if (out_fire) state_d = (idx_q == IDX_LAST) ? ST_IDLE : ST_MAC;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE) && !rst;
    bus.out_valid = (state_q == ST_OUT);
    bus.busy      = (state_q != ST_IDLE);
  end

  assign bus.out_data = out_data_q;
  assign bus.out_idx  = out_idx_q;
  assign bus.out_last = out_last_q;
  assign bus.cfg_err  = cfg_err_q;

  // MAC operand selection: cycle 0 uses Wx[i]*x, cycle k uses Wh[i][k-1]*h_prev[k-1].
  always_comb begin
    wx_sel = '0;
    b_sel  = '0;
    wh_sel = '0;
    hp_sel = '0;
    for (int n = 0; n < H; n++) begin
      if (int'(idx_q) == n) begin
        wx_sel = wx_q[n];
        b_sel  = b_q[n];
        for (int j = 0; j < H; j++)
          if (int'(cnt_q) == j + 1) wh_sel = wh_q[n*H + j];
      end
      if (int'(cnt_q) == n + 1) hp_sel = h_prev_q[n];
    end
    if (cnt_q == '0) begin
      mul_a = wx_sel;
      mul_b = x_q;
    end else begin
      mul_a = wh_sel;
      mul_b = hp_sel;
    end
  end

  assign prod     = prod_t'(mul_a) * prod_t'(mul_b);
  assign prod_ext = acc_t'(prod);
  assign bias_ext = acc_t'(b_sel) <<< FRAC_BITS;

  rnn_act_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_act (
    .acc  (acc_q),
    .mode (MODE),
    .y    (act_y)
  );

  always_comb begin
    wx_d       = wx_q;
    b_d        = b_q;
    wh_d       = wh_q;
    h_prev_d   = h_prev_q;
    h_next_d   = h_next_q;
    x_d        = x_q;
    seq_last_d = seq_last_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    out_last_d = out_last_q;
    cfg_err_d  = bus.cfg_we && !cfg_ok;

    if (cfg_ok) begin
      for (int n = 0; n < H; n++) begin
        if (cfg_a == wx_addr(n))   wx_d[n] = bus.cfg_wdata;
        if (cfg_a == b_addr(H, n)) b_d[n]  = bus.cfg_wdata;
        for (int j = 0; j < H; j++)
          if (cfg_a == wh_addr(H, n, j)) wh_d[n*H + j] = bus.cfg_wdata;
      end
    end

    case (state_q)
      // Input capture: a first beat starts the recurrence from zero state.
      ST_IDLE: begin
        if (in_fire) begin
          x_d        = bus.in_data;
          seq_last_d = bus.in_last;
          idx_d      = '0;
          cnt_d      = '0;
          if (bus.in_first)
            for (int n = 0; n < H; n++) h_prev_d[n] = '0;
        end
      end
      // Accumulate: bias and input term first, then one recurrent term per cycle.
      ST_MAC: begin
        acc_d = ((cnt_q == '0) ? bias_ext : acc_q) + prod_ext;
        cnt_d = cnt_q + CNT_W'(1);
      end
      // Activation: result goes both to the output register and the next-state buffer.
      ST_ACT: begin
        out_data_d = act_y;
        out_idx_d  = idx_q;
        out_last_d = seq_last_q && (idx_q == IDX_LAST);
        for (int n = 0; n < H; n++)
          if (int'(idx_q) == n) h_next_d[n] = act_y;
      end
      // Output hold: h_prev is only replaced once every neuron of the step has been read.
      ST_OUT: begin
        if (out_fire) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) h_prev_d = h_next_q;
          else                   idx_d = idx_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wx_q       <= '{default: '0};
      b_q        <= '{default: '0};
      wh_q       <= '{default: '0};
      h_prev_q   <= '{default: '0};
      h_next_q   <= '{default: '0};
      x_q        <= '0;
      seq_last_q <= 1'b0;
      acc_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      wx_q       <= wx_d;
      b_q        <= b_d;
      wh_q       <= wh_d;
      h_prev_q   <= h_prev_d;
      h_next_q   <= h_next_d;
      x_q        <= x_d;
      seq_last_q <= seq_last_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      out_last_q <= out_last_d;
      cfg_err_q  <= cfg_err_d;
    end
  end
endmodule

// File: tb/tb_rnn_cell_engine.sv
// Bench for rnn_cell_engine: a hard-tanh and a ReLU instance share one
// stimulus stream (H=4, Q8.8), so each step checks both activations.
module tb_rnn_cell_engine;
  import rnn_pkg::*;

  localparam int DW     = 16;
  localparam int H      = 4;
  localparam int ADDR_W = $clog2(2*H + H*H);
  localparam int NV     = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   hs_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rnn_cell_engine_if #(.DATA_WIDTH(DW), .HIDDEN_SIZE(H)) bt ();
  rnn_cell_engine_if #(.DATA_WIDTH(DW), .HIDDEN_SIZE(H)) br ();

  assign br.cfg_we    = bt.cfg_we;
  assign br.cfg_addr  = bt.cfg_addr;
  assign br.cfg_wdata = bt.cfg_wdata;
  assign br.in_valid  = bt.in_valid;
  assign br.in_data   = bt.in_data;
  assign br.in_first  = bt.in_first;
  assign br.in_last   = bt.in_last;
  assign br.out_ready = bt.out_ready;

  rnn_cell_engine #(.DATA_WIDTH(DW), .FRAC_BITS(8), .HIDDEN_SIZE(H), .ACC_WIDTH(40), .ACT_MODE(0))
    u_tanh (.clk(clk), .rst(rst), .bus(bt));
  rnn_cell_engine #(.DATA_WIDTH(DW), .FRAC_BITS(8), .HIDDEN_SIZE(H), .ACC_WIDTH(40), .ACT_MODE(1))
    u_relu (.clk(clk), .rst(rst), .bus(br));

  typedef struct {
    bit load;
    int wx;
    int b;
    int whd;
    int x;
    bit first;
    bit last;
    int stall;
    int exp_t;
    int exp_r;
  } vec_t;

  vec_t tbl[NV];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timed out", nm);
  endtask

  // Called at a negedge; returns at the following negedge with cfg_err visible.
  task automatic cfg_write(input int a, input int d);
    bt.cfg_we    = 1'b1;
    bt.cfg_addr  = a[ADDR_W-1:0];
    bt.cfg_wdata = d[DW-1:0];
    @(negedge clk);
    bt.cfg_we    = 1'b0;
  endtask

  task automatic load(input int wx, input int b, input int whd);
    for (int i = 0; i < H; i++) begin
      cfg_write(wx_addr(i), wx);
      cfg_write(b_addr(H, i), b);
      for (int j = 0; j < H; j++) cfg_write(wh_addr(H, i, j), (i == j) ? whd : 0);
    end
  endtask

  task automatic start_step(input int x, input bit first, input bit last, input string tag);
    int w;
    bt.in_valid = 1'b1;
    bt.in_data  = x[DW-1:0];
    bt.in_first = first;
    bt.in_last  = last;
    w = 0;
    while (bt.in_ready !== 1'b1 && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (bt.in_ready !== 1'b1) timeout({tag, "_in_ready"});
    @(posedge clk);
    @(negedge clk);
    hs_cyc      = cyc;
    bt.in_valid = 1'b0;
    bt.in_first = 1'b0;
    bt.in_last  = 1'b0;
  endtask

  task automatic collect(input int n, input int exp_t, input int exp_r, input bit last,
                         input int stall_idx, input string tag);
    for (int k = 0; k < n; k++) begin
      int w;
      w = 0;
      while (bt.out_valid !== 1'b1 && w < 64) begin
        @(negedge clk);
        w++;
      end
      if (bt.out_valid !== 1'b1) begin
        timeout($sformatf("%s_out_valid%0d", tag, k));
        return;
      end
      if (k == 0) chk({tag, "_latency"}, cyc - hs_cyc, H + 2);
      chk($sformatf("%s_tanh%0d", tag, k), int'(bt.out_data), exp_t);
      chk($sformatf("%s_relu%0d", tag, k), int'(br.out_data), exp_r);
      chk($sformatf("%s_idx%0d", tag, k), int'(bt.out_idx), k);
      chk($sformatf("%s_last%0d", tag, k), int'(bt.out_last), int'(last && k == H - 1));
      if (k == stall_idx) begin
        bt.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk($sformatf("%s_hold_valid%0d", tag, s), int'(bt.out_valid), 1);
          chk($sformatf("%s_hold_data%0d", tag, s), int'(bt.out_data), exp_t);
          chk($sformatf("%s_hold_idx%0d", tag, s), int'(bt.out_idx), k);
          chk($sformatf("%s_hold_in_ready%0d", tag, s), int'(bt.in_ready), 0);
        end
        bt.out_ready = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    tbl[0] = '{1,    256,   0,   0,   128, 1, 1, -1,  128,   128};
    tbl[1] = '{1,    256,   0, 256,   128, 1, 0, -1,  128,   128};
    tbl[2] = '{0,      0,   0,   0,   128, 0, 0,  1,  256,   256};
    tbl[3] = '{0,      0,   0,   0,   128, 0, 1, -1,  256,   384};
    tbl[4] = '{0,      0,   0,   0,   128, 1, 1, -1,  128,   128};
    tbl[5] = '{1,   -256,   0,   0,   128, 1, 1, -1, -128,     0};
    tbl[6] = '{1,  32767,   0,   0, 32767, 1, 1, -1,  256, 32767};
    tbl[7] = '{1,      0, 128,   0,   100, 1, 1, -1,  128,   128};
    tbl[8] = '{1, -32768,   0,   0, 32767, 1, 1, -1, -256,     0};
    tbl[9] = '{1,      1,  -1,   0,     1, 1, 1, -1,   -1,     0};

    bt.cfg_we = 1'b0; bt.cfg_addr = '0; bt.cfg_wdata = '0;
    bt.in_valid = 1'b0; bt.in_data = '0; bt.in_first = 1'b0; bt.in_last = 1'b0;
    bt.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(bt.in_ready), 0);
    chk("rst_out_valid", int'(bt.out_valid), 0);
    chk("rst_out_data", int'(bt.out_data), 0);
    chk("rst_out_idx", int'(bt.out_idx), 0);
    chk("rst_out_last", int'(bt.out_last), 0);
    chk("rst_cfg_err", int'(bt.cfg_err), 0);
    chk("rst_busy", int'(bt.busy), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", int'(bt.in_ready), 1);
    @(negedge clk);

    for (int r = 0; r < NV; r++) begin
      string tag;
      tag = $sformatf("v%0d", r);
      if (tbl[r].load) begin
        load(tbl[r].wx, tbl[r].b, tbl[r].whd);
        chk({tag, "_cfg_err"}, int'(bt.cfg_err), 0);
      end
      start_step(tbl[r].x, tbl[r].first, tbl[r].last, tag);
      collect(H, tbl[r].exp_t, tbl[r].exp_r, tbl[r].last, tbl[r].stall, tag);
    end

    // Dropped writes: one while busy, one past the end of the map while idle.
    load(256, 0, 0);
    start_step(128, 1'b1, 1'b1, "cfgbusy");
    cfg_write(wx_addr(0), 0);
    chk("cfgbusy_err", int'(bt.cfg_err), 1);
    collect(H, 128, 128, 1'b1, -1, "cfgbusy");
    cfg_write(wh_addr(H, H, 0), 77);
    chk("cfgrange_err", int'(bt.cfg_err), 1);
    @(negedge clk);
    chk("cfgrange_err_pulse", int'(bt.cfg_err), 0);
    cfg_write(wh_addr(H, H - 1, H - 1), 0);
    chk("cfgvalid_err", int'(bt.cfg_err), 0);
    start_step(128, 1'b1, 1'b1, "cfgafter");
    collect(H, 128, 128, 1'b1, -1, "cfgafter");

    // Reset while neuron 2 is accumulating.
    load(256, 0, 256);
    start_step(128, 1'b1, 1'b0, "midrst");
    collect(2, 128, 128, 1'b0, -1, "midrst");
    repeat (2) @(negedge clk);
    chk("midrst_busy_before", int'(bt.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", int'(bt.out_valid), 0);
    chk("midrst_busy", int'(bt.busy), 0);
    chk("midrst_busy_relu", int'(br.busy), 0);
    chk("midrst_in_ready", int'(bt.in_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    start_step(128, 1'b0, 1'b1, "afterrst");
    collect(H, 0, 0, 1'b1, -1, "afterrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end
endmodule

// File: doc/rnn_cell_engine.md
Name: rnn_cell_engine

Overview:
Streaming, parametrised Elman RNN cell: h_t = act(Wx*x_t + Wh*h_{t-1} + b). It replaces the fixed-length, whole-array RNN block with a valid/ready scalar input stream, a run-time loadable weight store, selectable activation, and a per-neuron hidden-state output stream. It uses one time-multiplexed MAC and sits between the feature front-end and the classifier head.

Parameters:
DATA_WIDTH, 16, signed fixed-point width of x, weights, bias and h (Qm.FRAC_BITS).
FRAC_BITS, 8, fractional bits; 1.0 = 1<<FRAC_BITS.
HIDDEN_SIZE, 8, number of neurons H (>=2).
ACC_WIDTH, 40, signed accumulator width; must be >= 2*DATA_WIDTH+$clog2(H+2).
ACT_MODE, 0, 0 = hard-tanh (clip to +/-1.0), 1 = ReLU (saturating).
ADDR_W, $clog2(2*H+H*H), config address width.

Ports:
clk  in  1  clock; one clock.
rst  in  1  reset is synchronous and active-high.
cfg_we  in  1  weight write strobe.
cfg_addr  in  ADDR_W  0..H-1 = Wx[i]; H..2H-1 = b[i]; 2H+i*H+j = Wh[i][j].
cfg_wdata  in  DATA_WIDTH  weight value.
cfg_err  out  1  one-cycle pulse: write dropped (busy or address out of range).
in_valid  in  1  input sample valid.
in_ready  out  1  engine accepts a sample.
in_data  in  DATA_WIDTH  x_t.
in_first  in  1  first step of a sequence; h_prev treated as zero.
in_last  in  1  last step of a sequence.
out_valid  out  1  h_t[out_idx] valid.
out_ready  in  1  downstream accepts.
out_data  out  DATA_WIDTH  activated neuron value.
out_idx  out  $clog2(H)  neuron index.
out_last  out  1  last neuron of the last step of a sequence.
busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE; all weights, bias, h_prev and h_next = 0; in_ready=0 during rst and 1 in the following cycle; out_valid=0, out_data=0, out_idx=0, out_last=0, cfg_err=0, busy=0. Reset mid-step aborts the step and discards partial results.
- FSM: IDLE -> MAC -> ACT -> OUT -> (MAC for the next neuron | IDLE).
- IDLE: in_ready=1. On in_valid&in_ready: latch x, in_last into seq_last, i=0; if in_first, zero h_prev in the same edge; go to MAC.
- MAC, H+1 cycles for neuron i: cycle 0 sets acc = sext(b[i])<<FRAC_BITS + Wx[i]*x; cycle k (1..H) adds Wh[i][k-1]*h_prev[k-1]. Products are full-width signed and sign-extended to ACC_WIDTH; no overflow is possible.
- ACT, 1 cycle: v = acc >>> FRAC_BITS (arithmetic shift, floor).
  - Mode 0: clip v to [-(1<<FRAC_BITS), +(1<<FRAC_BITS)].
  - Mode 1: negative v becomes 0; v > 2^(DW-1)-1 becomes 2^(DW-1)-1.
  - Register the result into out_data and h_next[i]; out_idx=i; out_last = seq_last & (i==H-1).
- OUT: out_valid=1, with out_data, out_idx and out_last held stable until out_ready.
  - On handshake, if i<H-1: i++ and go to MAC.
  - On handshake, if i==H-1: h_prev<=h_next (all H words, same edge) and go to IDLE.
- Latency: out_valid rises on the (H+2)th edge after the input handshake edge. With out_ready held at 1, each neuron takes H+3 cycles and a step takes H*(H+3) cycles before in_ready returns.
- in_first and in_last in the same beat: a one-step sequence. out_last marks the last neuron of that step.
- Without in_first, the state carries over across steps and across sequences, including after a sequence ended with in_last.
- Config port:
  - A write takes effect at the edge when busy=0 and the address is < 2H+H*H.
  - Otherwise the write is dropped, contents are unchanged, and cfg_err pulses one cycle later.
  - A cfg write and an input handshake in the same IDLE cycle: the write lands first and the step uses the new weight.
- Input beats are never dropped; in_valid may stay high while in_ready=0.

Decomposition:
- rnn_pkg holds:
  - the act_mode_e enum (ACT_TANH=0, ACT_RELU=1);
  - the FSM state enum;
  - address-map helper functions wx_addr(i), b_addr(i) and wh_addr(i,j);
  - an acc_width(DW,H) constant function.
- Sub-module rnn_act_sat: combinational shift, activation and saturation (acc, mode -> DATA_WIDTH). It is shared with the future LSTM gate block.

Test Plan:
- Load Wx=256, Wh=0, b=0 (H=4, mode 0); x=128 with first=last=1 -> outputs 128,128,128,128, idx 0..3, out_last on idx 3 only; first out_valid 6 edges after the input handshake.
- Recurrence: Wx=256, Wh=identity*256, b=0; x=128,128,128 (first on step 0) -> step outputs 128, 256, 256 (clip at 1.0); then x=128 with first=1 -> 128.
- ReLU mode: Wx=-256, x=128 -> 0; Wx=0x7FFF, x=0x7FFF -> 0x7FFF saturated; b=0x0080, Wx=0 -> 128.
- Backpressure: hold out_ready=0 for 5 cycles at idx 1 -> out_valid, out_data and out_idx stable; in_ready stays 0; values are correct after release.
- Config errors: write Wx[0] while busy=1, and write to addr 2H+H*H while idle -> cfg_err pulse each time; subsequent outputs show the old weights.
- Assert rst mid-MAC of neuron 2 -> next cycle out_valid=0 and busy=0; the next step (no in_first) uses h_prev=0 and zeroed weights -> all outputs 0.
